md_unit: RTL and testbench

Execute-stage multiply/divide unit of the MIPS pipeline. Consumes the decoded instruction's operands from the ID/EX pipeline register (rs and rt values), runs MULT/MULTU/DIV/DIVU with a fixed multi-cycle latency, and owns the architectural HI/LO registers. The hazard unit uses `busy` to stall HI/LO-dependent instructions in decode.

---
 rtl/md_unit.sv | 123 ++++++++++++
 tb/tb_md_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// md_unit : MIPS E-stage multiply/divide unit owning HI/LO; optional MD_MADD_EN
// rev 1.0
// ============================================================================
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic        int_clr,
   input  logic [31:0] rs_in,
   input  logic [31:0] rt_in,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy
);

   localparam logic [4:0] C_MULT_CNT = 5'(MULT_CYCLES);
   localparam logic [4:0] C_DIV_CNT  = 5'(DIV_CYCLES);

   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic [4:0]  cnt_q, cnt_d;

   logic        op_signed;
   logic        is_div;
   logic        op_ok;
   logic        accept;
   logic        mt_ok;
   logic [63:0] mul_a, mul_b, prod;
   logic [31:0] div_a_mag, div_b_mag, div_b_safe;
   logic [31:0] quot_mag, rem_mag, quot, rem;
   logic [63:0] div_res;
   logic [63:0] md_res;
`ifdef MD_MADD_EN
   logic [63:0] acc;
`endif

   // Datapath: one 64-bit multiplier serves signed and unsigned by extension choice.
   always_comb begin
      op_signed  = ~md_op[0];
      is_div     = (md_op[2:1] == 2'b01);
      mul_a      = {{32{op_signed & rs_in[31]}}, rs_in};
      mul_b      = {{32{op_signed & rt_in[31]}}, rt_in};
      prod       = mul_a * mul_b;

      div_a_mag  = (op_signed && rs_in[31]) ? (32'd0 - rs_in) : rs_in;
      div_b_mag  = (op_signed && rt_in[31]) ? (32'd0 - rt_in) : rt_in;
      div_b_safe = (div_b_mag == 32'd0) ? 32'd1 : div_b_mag;
      quot_mag   = div_a_mag / div_b_safe;
      rem_mag    = div_a_mag % div_b_safe;
      quot       = (op_signed && (rs_in[31] ^ rt_in[31])) ? (32'd0 - quot_mag) : quot_mag;
      rem        = (op_signed && rs_in[31]) ? (32'd0 - rem_mag) : rem_mag;
      // Divide by zero re-commits the current HI/LO so the result is a no-op.
      div_res    = (rt_in == 32'd0) ? {hi_q, lo_q} : {rem, quot};

`ifdef MD_MADD_EN
      acc        = md_op[1] ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
      op_ok      = 1'b1;
      md_res     = is_div ? div_res : (md_op[2] ? acc : prod);
`else
      op_ok      = ~md_op[2];
      md_res     = is_div ? div_res : prod;
`endif
   end

   // Control: a qualified start pre-empts any same-cycle MTHI/MTLO.
   always_comb begin
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      cnt_d     = cnt_q;

      accept = start && (cnt_q == 5'd0) && !int_clr && op_ok;
      mt_ok  = !start && (cnt_q == 5'd0) && !int_clr;

      if (accept) begin
         pend_hi_d = md_res[63:32];
         pend_lo_d = md_res[31:0];
         cnt_d     = is_div ? C_DIV_CNT : C_MULT_CNT;
      end else if (cnt_q == 5'd1) begin
         hi_d  = pend_hi_q;
         lo_d  = pend_lo_q;
         cnt_d = 5'd0;
      end else if (cnt_q > 5'd1) begin
         cnt_d = cnt_q - 5'd1;
      end else if (mt_ok) begin
         if (hi_we) hi_d = rs_in;
         if (lo_we) lo_d = rs_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         cnt_q     <= 5'd0;
      end else begin
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         cnt_q     <= cnt_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (cnt_q != 5'd0);

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// tb_md_unit : directed self-checking bench for md_unit
// rev 1.0
// ============================================================================
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  md_op = 3'b000;
   logic        hi_we = 1'b0;
   logic        lo_we = 1'b0;
   logic        int_clr = 1'b0;
   logic [31:0] rs_in = 32'd0;
   logic [31:0] rt_in = 32'd0;
   logic [31:0] hi, lo;
   logic        busy;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc;

   localparam logic [2:0] C_MULT  = 3'b000;
   localparam logic [2:0] C_MULTU = 3'b001;
   localparam logic [2:0] C_DIV   = 3'b010;
   localparam logic [2:0] C_DIVU  = 3'b011;
   localparam logic [2:0] C_MADDU = 3'b101;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op),
      .hi_we(hi_we), .lo_we(lo_we), .int_clr(int_clr),
      .rs_in(rs_in), .rt_in(rt_in), .hi(hi), .lo(lo), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the first negedge with busy low.
   // With inject set, a second start is driven while the first op is in flight.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit inject, output int cycles);
      start = 1'b1; md_op = op; rs_in = a; rt_in = b;
      @(negedge clk);
      start = 1'b0;
      cycles = 0;
      while (busy && cycles < 64) begin
         cycles++;
         if (inject && cycles == 2) begin
            start = 1'b1; md_op = C_DIV; rs_in = 32'd1; rt_in = 32'd1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic mt(input bit is_hi, input logic [31:0] v);
      hi_we = is_hi; lo_we = !is_hi; rs_in = v;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      mt(1'b1, 32'hAAAA5555);
      mt(1'b0, 32'h12345678);
      check("mthi", hi, 32'hAAAA5555);
      check("mtlo", lo, 32'h12345678);

      // Reset asserted in cycle 4 of a DIV
      start = 1'b1; md_op = C_DIV; rs_in = 32'd100; rt_in = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("div_midflight_busy", 32'(busy), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_hi", hi, 32'd0);
      check("midrst_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      run_op(C_MULT, 32'hFFFFFFFF, 32'd2, 1'b0, cyc);
      check("mult_cycles", 32'(cyc), 32'd5);
      check("mult_hi", hi, 32'hFFFFFFFF);
      check("mult_lo", lo, 32'hFFFFFFFE);

      run_op(C_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, cyc);
      check("multu_cycles", 32'(cyc), 32'd5);
      check("multu_hi", hi, 32'd1);
      check("multu_lo", lo, 32'hFFFFFFFE);

      run_op(C_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, cyc);
      check("div_cycles", 32'(cyc), 32'd10);
      check("div_lo", lo, 32'hFFFFFFFD);
      check("div_hi", hi, 32'hFFFFFFFF);

      run_op(C_DIVU, 32'd7, 32'd0, 1'b0, cyc);
      check("div0_cycles", 32'(cyc), 32'd10);
      check("div0_hi", hi, 32'hFFFFFFFF);
      check("div0_lo", lo, 32'hFFFFFFFD);

      run_op(C_DIVU, 32'd100, 32'd7, 1'b0, cyc);
      check("divu_lo", lo, 32'd14);
      check("divu_hi", hi, 32'd2);

      run_op(C_DIV, 32'd7, 32'hFFFFFFFE, 1'b0, cyc);
      check("div_negdiv_lo", lo, 32'hFFFFFFFD);
      check("div_negdiv_hi", hi, 32'd1);

      run_op(C_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, cyc);
      check("div_ovf_lo", lo, 32'h80000000);
      check("div_ovf_hi", hi, 32'd0);

      // Flush cancels start and MTHI
      start = 1'b1; int_clr = 1'b1; md_op = C_MULT; rs_in = 32'd3; rt_in = 32'd3;
      @(negedge clk);
      start = 1'b0; int_clr = 1'b0;
      check("intclr_busy", 32'(busy), 32'd0);
      check("intclr_lo", lo, 32'h80000000);
      hi_we = 1'b1; int_clr = 1'b1; rs_in = 32'h1234;
      @(negedge clk);
      hi_we = 1'b0; int_clr = 1'b0;
      check("intclr_mthi", hi, 32'd0);

      run_op(C_MULT, 32'd3, 32'd4, 1'b1, cyc);
      check("inject_cycles", 32'(cyc), 32'd5);
      check("inject_hi", hi, 32'd0);
      check("inject_lo", lo, 32'd12);

      lo_we = 1'b1;
      run_op(C_MULTU, 32'd3, 32'd5, 1'b0, cyc);
      lo_we = 1'b0;
      check("start_lowe_lo", lo, 32'd15);
      check("start_lowe_hi", hi, 32'd0);

      mt(1'b1, 32'd0);
      mt(1'b0, 32'hFFFFFFFF);
      run_op(C_MADDU, 32'd1, 32'd1, 1'b0, cyc);
`ifdef MD_MADD_EN
      check("maddu_cycles", 32'(cyc), 32'd5);
      check("maddu_hi", hi, 32'd1);
      check("maddu_lo", lo, 32'd0);
`else
      check("maddu_off_cycles", 32'(cyc), 32'd0);
      check("maddu_off_hi", hi, 32'd0);
      check("maddu_off_lo", lo, 32'hFFFFFFFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
